major_cycle_sequencer: RTL and testbench

Timing generator that produces the per-cycle clock/strobe slots for the Fetch, Auto-increment and Indirect major cycles. It drives the ck*/stb* inputs of the instruction-fetch control decoder. It samples the decoded addressing-mode flags after fetch, so it sequences only the cycles the current instruction needs. It then hands off to the execute logic with a start/done handshake, and loops to the next fetch while running.

---
 rtl/major_cycle_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_major_cycle_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/major_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// major_cycle_sequencer
//
// Timing generator for the Fetch, Auto-increment and Indirect major cycles of
// the instruction-fetch path. It produces the ck*/stb* slot signals that drive
// the fetch control decoder. After each fetch it looks at the decoded
// addressing-mode flags, so only the major cycles the current instruction
// needs are sequenced. Then it hands control to the execute logic with a
// start/done handshake. While run is high it loops straight back to the next
// fetch.
//
// Parameters
//   CK_LEN       cycles each ck* slot stays high (1..15); the matching stb*
//                fires on the last of them
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high; returns to IDLE with outputs low
//   run          level; free-run instructions, looked at on boundaries only
//   step         one-cycle pulse; single instruction from IDLE when run is low
//   instIsIND    instruction is plain indirect (valid from stbFetch+1)
//   instIsPPIND  instruction is indirect via auto-index location
//   execDone     execute logic finished; looked at in EXEC
//   ckFetch      fetch slot clock (RAM read of PC location)
//   stbFetch     fetch strobe on last ckFetch cycle (IR latch)
//   stbFetch2    post-fetch strobe (PC increment) in the gap after fetch
//   ckAuto1      autoincrement slot 1 clock
//   stbAuto1     autoincrement slot 1 strobe
//   ckAuto2      autoincrement slot 2 clock
//   stbAuto2     autoincrement slot 2 strobe (write-back)
//   ckInd        indirect slot clock
//   stbInd       indirect slot strobe
//   execStart    one-cycle pulse on the first EXEC cycle
//   busy         high in every state except IDLE
// ---------------------------------------------------------------------------
module major_cycle_sequencer #(
  parameter int CK_LEN = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic step,
  input  logic instIsIND,
  input  logic instIsPPIND,
  input  logic execDone,
  output logic ckFetch,
  output logic stbFetch,
  output logic stbFetch2,
  output logic ckAuto1,
  output logic stbAuto1,
  output logic ckAuto2,
  output logic stbAuto2,
  output logic ckInd,
  output logic stbInd,
  output logic execStart,
  output logic busy
);

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    FETCH2,
    AUTO1,
    GAP1,
    AUTO2,
    GAP2,
    IND,
    GAP3,
    EXEC
  } state_t;

  // Counter value reached on the last cycle of a ck* slot.
  localparam logic [3:0] SLOT_LAST = 4'(CK_LEN - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] slot_cnt;
  logic [3:0] slot_cnt_next;
  logic       slot_last;
  logic       slot_last_next;

  logic ck_fetch_next;
  logic stb_fetch_next;
  logic stb_fetch2_next;
  logic ck_auto1_next;
  logic stb_auto1_next;
  logic ck_auto2_next;
  logic stb_auto2_next;
  logic ck_ind_next;
  logic stb_ind_next;
  logic exec_start_next;
  logic busy_next;

  assign slot_last      = (slot_cnt == SLOT_LAST);
  assign slot_last_next = (slot_cnt_next == SLOT_LAST);

  // State, slot counter and every output are registered together. The
  // outputs are decoded from the next state and next counter, so the
  // registered outputs always describe the state the block is in now.
  // Reset wins over everything, including a slot that is half way through,
  // so no strobe can complete once reset has been seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      slot_cnt  <= 4'd0;
      ckFetch   <= 1'b0;
      stbFetch  <= 1'b0;
      stbFetch2 <= 1'b0;
      ckAuto1   <= 1'b0;
      stbAuto1  <= 1'b0;
      ckAuto2   <= 1'b0;
      stbAuto2  <= 1'b0;
      ckInd     <= 1'b0;
      stbInd    <= 1'b0;
      execStart <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      slot_cnt  <= slot_cnt_next;
      ckFetch   <= ck_fetch_next;
      stbFetch  <= stb_fetch_next;
      stbFetch2 <= stb_fetch2_next;
      ckAuto1   <= ck_auto1_next;
      stbAuto1  <= stb_auto1_next;
      ckAuto2   <= ck_auto2_next;
      stbAuto2  <= stb_auto2_next;
      ckInd     <= ck_ind_next;
      stbInd    <= stb_ind_next;
      execStart <= exec_start_next;
      busy      <= busy_next;
    end
  end

  // Next-state logic. The counter defaults to zero so that every state
  // entry reloads it; slot states count up until their last cycle. In
  // EXEC the counter parks at 1 after the first cycle, which is what marks
  // that first cycle for execStart.
  // The addressing-mode flags are only looked at on the FETCH2 edge, and
  // the choice they make is captured in the state register, so later
  // changes on them cannot disturb the instruction in flight.
  always_comb begin
    state_next    = state;
    slot_cnt_next = 4'd0;
    unique case (state)
      IDLE: begin
        if (run || step) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (slot_last) begin
          state_next = FETCH2;
        end else begin
          slot_cnt_next = slot_cnt + 4'd1;
        end
      end
      FETCH2: begin
        if (instIsPPIND) begin
          state_next = AUTO1;
        end else if (instIsIND) begin
          state_next = IND;
        end else begin
          state_next = EXEC;
        end
      end
      AUTO1: begin
        if (slot_last) begin
          state_next = GAP1;
        end else begin
          slot_cnt_next = slot_cnt + 4'd1;
        end
      end
      GAP1: begin
        state_next = AUTO2;
      end
      AUTO2: begin
        if (slot_last) begin
          state_next = GAP2;
        end else begin
          slot_cnt_next = slot_cnt + 4'd1;
        end
      end
      GAP2: begin
        state_next = IND;
      end
      IND: begin
        if (slot_last) begin
          state_next = GAP3;
        end else begin
          slot_cnt_next = slot_cnt + 4'd1;
        end
      end
      GAP3: begin
        state_next = EXEC;
      end
      EXEC: begin
        if (execDone) begin
          state_next = run ? FETCH : IDLE;
        end else begin
          slot_cnt_next = 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode from the next state and counter. Each slot raises its
  // own ck* for the whole slot and its stb* only on the last slot cycle.
  // Gap states are silent apart from FETCH2, which carries stbFetch2.
  always_comb begin
    ck_fetch_next   = 1'b0;
    stb_fetch_next  = 1'b0;
    stb_fetch2_next = 1'b0;
    ck_auto1_next   = 1'b0;
    stb_auto1_next  = 1'b0;
    ck_auto2_next   = 1'b0;
    stb_auto2_next  = 1'b0;
    ck_ind_next     = 1'b0;
    stb_ind_next    = 1'b0;
    exec_start_next = 1'b0;
    busy_next       = (state_next != IDLE);
    case (state_next)
      FETCH: begin
        ck_fetch_next  = 1'b1;
        stb_fetch_next = slot_last_next;
      end
      FETCH2: begin
        stb_fetch2_next = 1'b1;
      end
      AUTO1: begin
        ck_auto1_next  = 1'b1;
        stb_auto1_next = slot_last_next;
      end
      AUTO2: begin
        ck_auto2_next  = 1'b1;
        stb_auto2_next = slot_last_next;
      end
      IND: begin
        ck_ind_next  = 1'b1;
        stb_ind_next = slot_last_next;
      end
      EXEC: begin
        exec_start_next = (slot_cnt_next == 4'd0);
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_major_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for major_cycle_sequencer. Two instances (CK_LEN=2 and CK_LEN=3)
// share one set of inputs. A queue-based model turns each instruction into
// the list of per-cycle output words it must produce. Every cycle the DUTs
// are compared against that model, and directed cycle tables pin both the
// model and the DUTs to hand-computed values.
//
// Output word layout (bit 10 .. bit 0):
//   busy execStart stbInd ckInd stbAuto2 ckAuto2 stbAuto1 ckAuto1
//   stbFetch2 stbFetch ckFetch
// ---------------------------------------------------------------------------
module tb_major_cycle_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic run;
  logic step;
  logic instIsIND;
  logic instIsPPIND;
  logic execDone;

  logic d2_ckFetch, d2_stbFetch, d2_stbFetch2, d2_ckAuto1, d2_stbAuto1;
  logic d2_ckAuto2, d2_stbAuto2, d2_ckInd, d2_stbInd, d2_execStart, d2_busy;
  logic d3_ckFetch, d3_stbFetch, d3_stbFetch2, d3_ckAuto1, d3_stbAuto1;
  logic d3_ckAuto2, d3_stbAuto2, d3_ckInd, d3_stbInd, d3_execStart, d3_busy;

  major_cycle_sequencer #(.CK_LEN(2)) u_dut2 (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .instIsIND(instIsIND), .instIsPPIND(instIsPPIND), .execDone(execDone),
    .ckFetch(d2_ckFetch), .stbFetch(d2_stbFetch), .stbFetch2(d2_stbFetch2),
    .ckAuto1(d2_ckAuto1), .stbAuto1(d2_stbAuto1),
    .ckAuto2(d2_ckAuto2), .stbAuto2(d2_stbAuto2),
    .ckInd(d2_ckInd), .stbInd(d2_stbInd),
    .execStart(d2_execStart), .busy(d2_busy)
  );

  major_cycle_sequencer #(.CK_LEN(3)) u_dut3 (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .instIsIND(instIsIND), .instIsPPIND(instIsPPIND), .execDone(execDone),
    .ckFetch(d3_ckFetch), .stbFetch(d3_stbFetch), .stbFetch2(d3_stbFetch2),
    .ckAuto1(d3_ckAuto1), .stbAuto1(d3_stbAuto1),
    .ckAuto2(d3_ckAuto2), .stbAuto2(d3_stbAuto2),
    .ckInd(d3_ckInd), .stbInd(d3_stbInd),
    .execStart(d3_execStart), .busy(d3_busy)
  );

  logic [10:0] out2;
  logic [10:0] out3;
  assign out2 = {d2_busy, d2_execStart, d2_stbInd, d2_ckInd, d2_stbAuto2, d2_ckAuto2,
                 d2_stbAuto1, d2_ckAuto1, d2_stbFetch2, d2_stbFetch, d2_ckFetch};
  assign out3 = {d3_busy, d3_execStart, d3_stbInd, d3_ckInd, d3_stbAuto2, d3_ckAuto2,
                 d3_stbAuto1, d3_ckAuto1, d3_stbFetch2, d3_stbFetch, d3_ckFetch};

  localparam logic [10:0] V_BUSY   = 11'h400;
  localparam logic [10:0] V_FETCH2 = 11'h404;
  localparam logic [10:0] V_EXEC   = 11'h600;

  int checks = 0;
  int failures = 0;

  // Model state: per instance, a ring of upcoming output words plus a flag
  // for the open-ended execute phase.
  int          ck_len [2] = '{2, 3};
  logic [10:0] qbuf [2][64];
  int          qh [2];
  int          qt [2];
  logic [10:0] exp_vec [2];
  bit          in_exec [2];
  bit          started = 1'b0;

  task automatic push(input int i, input logic [10:0] v);
    qbuf[i][qt[i]] = v;
    qt[i] = (qt[i] + 1) % 64;
  endtask

  // A slot holds its clock bit for ck_len cycles; the strobe bit sits just
  // above the clock bit and is set on the final cycle only.
  task automatic push_slot(input int i, input int ck_bit);
    for (int k = 0; k < ck_len[i]; k++) begin
      logic [10:0] v;
      v = V_BUSY;
      v[ck_bit] = 1'b1;
      if (k == ck_len[i] - 1) v[ck_bit + 1] = 1'b1;
      push(i, v);
    end
  endtask

  task automatic push_fetch(input int i);
    push_slot(i, 0);
    push(i, V_FETCH2);
  endtask

  // Advance the model of instance i by one clock edge, using the inputs
  // present at that edge.
  task automatic model_edge(input int i);
    if (reset) begin
      qh[i] = 0;
      qt[i] = 0;
      in_exec[i] = 1'b0;
      exp_vec[i] = 11'h0;
      return;
    end
    if (in_exec[i]) begin
      if (execDone) begin
        in_exec[i] = 1'b0;
        if (run) push_fetch(i);
      end
    end else if (exp_vec[i] == V_FETCH2) begin
      if (instIsPPIND) begin
        push_slot(i, 3); push(i, V_BUSY);
        push_slot(i, 5); push(i, V_BUSY);
        push_slot(i, 7); push(i, V_BUSY);
      end else if (instIsIND) begin
        push_slot(i, 7); push(i, V_BUSY);
      end
      push(i, V_EXEC);
    end else if (qh[i] == qt[i]) begin
      if (run || step) push_fetch(i);
    end
    if (qh[i] != qt[i]) begin
      exp_vec[i] = qbuf[i][qh[i]];
      qh[i] = (qh[i] + 1) % 64;
      if (exp_vec[i] == V_EXEC) in_exec[i] = 1'b1;
    end else begin
      exp_vec[i] = in_exec[i] ? V_BUSY : 11'h0;
    end
  endtask

  always @(posedge clk) begin
    model_edge(0);
    model_edge(1);
    started = 1'b1;
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (out2 !== exp_vec[0]) begin
        failures++;
        $display("[TB] FAIL model_cmp_ck2 t=%0t got=%h want=%h", $time, out2, exp_vec[0]);
      end
      checks++;
      if (out3 !== exp_vec[1]) begin
        failures++;
        $display("[TB] FAIL model_cmp_ck3 t=%0t got=%h want=%h", $time, out3, exp_vec[1]);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic s, input logic ind,
                               input logic ppind, input logic done);
    run         = r;
    step        = s;
    instIsIND   = ind;
    instIsPPIND = ppind;
    execDone    = done;
  endtask

  task automatic checkOutput(input string name, input logic [10:0] got, input logic [10:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Pins both the DUT and the model of instance idx to a literal word.
  task automatic checkCycle(input string name, input int idx, input int c, input logic [10:0] want);
    logic [10:0] got;
    got = (idx == 0) ? out2 : out3;
    checkOutput($sformatf("%s_c%0d_dut", name, c), got, want);
    checkOutput($sformatf("%s_c%0d_model", name, c), exp_vec[idx], want);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((out2[10] || out3[10] || exp_vec[0] != 11'h0 || exp_vec[1] != 11'h0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_idle"}, {out3[10], 9'b0, out2[10]}, 11'h0);
  endtask

  // Hand-derived cycle tables (cycle 0 = cycle in which run/step is sampled).
  function automatic logic [10:0] expDirect(input int c);
    case (c)
      1: return 11'h401;
      2: return 11'h403;
      3: return 11'h404;
      4: return 11'h600;
      5: return 11'h401;
      default: return 11'h000;
    endcase
  endfunction

  function automatic logic [10:0] expPp(input int c);
    case (c)
      1: return 11'h401;
      2: return 11'h403;
      3: return 11'h404;
      4: return 11'h408;
      5: return 11'h418;
      6: return 11'h400;
      7: return 11'h420;
      8: return 11'h460;
      9: return 11'h400;
      10: return 11'h480;
      11: return 11'h580;
      12: return 11'h400;
      13: return 11'h600;
      default: return 11'h000;
    endcase
  endfunction

  function automatic logic [10:0] expInd3(input int c);
    case (c)
      1: return 11'h401;
      2: return 11'h401;
      3: return 11'h403;
      4: return 11'h404;
      5: return 11'h480;
      6: return 11'h480;
      7: return 11'h580;
      8: return 11'h400;
      9: return 11'h600;
      default: return 11'h000;
    endcase
  endfunction

  function automatic logic [10:0] expStep(input int c);
    case (c)
      1: return 11'h401;
      2: return 11'h403;
      3: return 11'h404;
      4: return 11'h600;
      5, 6, 7, 8: return 11'h400;
      default: return 11'h000;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    $display("[TB] idle after reset");
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checkCycle("idle_ck2", 0, c, 11'h000);
      checkCycle("idle_ck3", 1, c, 11'h000);
    end

    $display("[TB] direct instruction, free run");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checkCycle("direct", 0, c, expDirect(c));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    waitIdle("direct");

    $display("[TB] auto-index indirect, then both flags");
    for (int m = 0; m < 2; m++) begin
      applyStimulus(1'b1, 1'b0, (m == 1), 1'b1, 1'b1);
      for (int c = 1; c <= 14; c++) begin
        @(negedge clk);
        checkCycle((m == 0) ? "ppind" : "ppind_both", 0, c, expPp(c));
        if (c == 13) run = 1'b0;
      end
      waitIdle("ppind");
    end

    $display("[TB] indirect with CK_LEN=3");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checkCycle("ind_ck3", 1, c, expInd3(c));
      if (c == 9) run = 1'b0;
    end
    waitIdle("ind");

    $display("[TB] single step with slow execute");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      checkCycle("step", 0, c, expStep(c));
      if (c == 1) step = 1'b0;
      if (c == 6) step = 1'b1;
      if (c == 7) step = 1'b0;
      if (c == 8) execDone = 1'b1;
      if (c == 9) execDone = 1'b0;
    end
    waitIdle("step");

    $display("[TB] reset during auto slot 2");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      checkCycle("rst_pre", 0, c, expPp(c));
    end
    reset = 1'b1;
    run = 1'b0;
    for (int c = 8; c <= 12; c++) begin
      @(negedge clk);
      reset = 1'b0;
      checkCycle("rst_ck2", 0, c, 11'h000);
      checkCycle("rst_ck3", 1, c, 11'h000);
    end
    run = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checkCycle("restart", 0, c, expDirect(c));
    end
    run = 1'b0;
    waitIdle("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
